overture_io_port: RTL and testbench
===================================

OVERTURE_IO_PORT -- requirements
Module: overture_io_port

Interface
REQ-001 The block SHALL provide parameters, one per line:
- UUID, default 0, instance identifier, no functional effect.
- NAME, default "", instance label, no functional effect.
- DEPTH, default 8, entries per queue; power of two, 2..256.
REQ-002 The block SHALL provide ports, one per line (CW = log2(DEPTH)+1):
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- arch_input_enable  in  1  CPU requests an input byte this cycle.
- arch_input_value  out  8  byte presented to the CPU.
- arch_output_enable  in  1  CPU writes a byte this cycle.
- arch_output_value  in  8  byte written by the CPU.
- host_in_valid  in  1  host offers a byte for the input queue.
- host_in_data  in  8  host byte.
- host_in_ready  out  1  input queue accepts this cycle.
- host_out_valid  out  1  output queue holds a byte for the host.
- host_out_data  out  8  oldest captured CPU byte.
- host_out_ready  in  1  host takes host_out_data this cycle.
- in_count  out  CW  input queue occupancy.
- out_count  out  CW  output queue occupancy.
- underflow_err  out  1  sticky: CPU read while the input queue was empty.
- overflow_err  out  1  sticky: CPU write dropped because the output queue was full.
- err_clear  in  1  clears both sticky flags.

Function
REQ-003 The block SHALL act as the device end of the CPU arch I/O interface: it supplies bytes on reads and captures bytes on writes, with no stall path to the CPU.
REQ-004 The input queue SHALL be a FIFO of DEPTH bytes filled by the host and drained by the CPU.
REQ-005 host_in_ready SHALL equal (in_count < DEPTH); a host push occurs when host_in_valid && host_in_ready.
REQ-006 arch_input_value SHALL be combinational: the head byte when in_count > 0, else 8'h00.
REQ-007 A CPU read (arch_input_enable=1) with in_count > 0 SHALL pop the head at the clock edge.
REQ-008 A CPU read with in_count == 0 SHALL pop nothing, present 8'h00, and set underflow_err at the edge.
REQ-009 No fall-through: a byte pushed in cycle N SHALL be visible on arch_input_value no earlier than cycle N+1.
- Same-cycle push and pop on an empty queue is an underflow plus a successful push.
REQ-010 Same-cycle host push and CPU pop on a non-empty queue SHALL leave in_count unchanged.
REQ-011 The output queue SHALL be a FIFO of DEPTH bytes filled by the CPU and drained by the host.
REQ-012 A CPU write SHALL capture arch_output_value when out_count < DEPTH, or when out_count == DEPTH and a host pop occurs the same cycle.
REQ-013 Otherwise a CPU write SHALL be dropped and set overflow_err; queue contents SHALL be unchanged.
REQ-014 host_out_valid SHALL equal (out_count > 0); host_out_data SHALL be the oldest byte, 8'h00 when empty.
REQ-015 A host pop SHALL occur when host_out_valid && host_out_ready.
REQ-016 Pointers SHALL wrap modulo DEPTH; counts SHALL range over 0..DEPTH inclusive.
REQ-017 Sticky flags SHALL hold until err_clear or rst.
- If err_clear and a new error occur in the same cycle, the flag SHALL end the cycle set.
REQ-018 Queue data storage SHALL need no reset; only pointers, counts and flags are reset.

Reset
REQ-019 With rst=1 at a rising edge, all of the following SHALL hold after that edge, and all other inputs are ignored that cycle:
- both queues empty;
- in_count=0, out_count=0;
- underflow_err=0, overflow_err=0;
- host_in_ready=1, host_out_valid=0;
- arch_input_value=8'h00, host_out_data=8'h00.
REQ-020 Reset asserted mid-transfer SHALL discard all queued bytes without emitting any.

Verification
REQ-021 Reset, then host pushes 8'h11, 8'h22, 8'h33, then 3 CPU reads -> CPU sees 11, 22, 33 in order; in_count ends at 0; underflow_err=0.
REQ-022 CPU read with the input queue empty -> arch_input_value=00; underflow_err=1 next cycle; err_clear for one cycle -> flag returns to 0.
REQ-023 Host pushes DEPTH bytes -> host_in_ready=0 and a further push is refused; a CPU read and host push in the same cycle -> in_count stays DEPTH-1 after the pop, and the pushed byte is not lost.
REQ-024 CPU writes 8'hA0..8'hA7 (DEPTH=8) with host_out_ready=0, then writes 8'hFF -> 8'hFF dropped; overflow_err=1; host then drains A0..A7 in order.
REQ-025 Output queue full, CPU write and host pop in the same cycle -> write accepted; out_count stays 8; overflow_err stays 0.
REQ-026 rst asserted with both queues partly full -> counts 0 and flags 0 after the edge; host_out_valid=0; arch_input_value=00.

Source files
------------

// File: rtl/overture_io_port.sv
// rtl/overture_io_port.sv - device end of the CPU arch I/O interface with host-side byte queues
//
// overture_io_port_fifo: byte FIFO used for both directions.
//   clk, rst          clock and synchronous active-high reset (pointers/count only)
//   push, push_data   enqueue a byte at the rising edge (caller guarantees room)
//   pop               dequeue the head at the rising edge (caller guarantees data)
//   count             occupancy, 0..DEPTH
//   head              oldest byte, 8'h00 when empty
//
// overture_io_port: top level.
//   arch_input_enable/arch_input_value    CPU read side, value is combinational from the head
//   arch_output_enable/arch_output_value  CPU write side, captured when there is room
//   host_in_valid/host_in_data/host_in_ready     host feeds the input queue
//   host_out_valid/host_out_data/host_out_ready  host drains the output queue
//   in_count/out_count                    queue occupancies
//   underflow_err/overflow_err/err_clear  sticky error flags and their clear

module overture_io_port_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [7:0]    head
);

    // Data storage is never reset; an empty count masks whatever it holds.
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        // AW-bit pointers wrap modulo DEPTH on their own since DEPTH is a power of two.
        if (push) begin
            wr_d = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign count = count_q;
    // Head comes only from registered storage, so a byte pushed this cycle
    // cannot fall through to the reader before the next cycle.
    assign head  = (count_q != '0) ? mem_q[rd_q] : 8'h00;

endmodule

module overture_io_port #(
    parameter int UUID  = 0,
    parameter     NAME  = "",
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arch_input_enable,
    output logic [7:0]    arch_input_value,
    input  logic          arch_output_enable,
    input  logic [7:0]    arch_output_value,
    input  logic          host_in_valid,
    input  logic [7:0]    host_in_data,
    output logic          host_in_ready,
    output logic          host_out_valid,
    output logic [7:0]    host_out_data,
    input  logic          host_out_ready,
    output logic [CW-1:0] in_count,
    output logic [CW-1:0] out_count,
    output logic          underflow_err,
    output logic          overflow_err,
    input  logic          err_clear
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Instance identification only.
    logic unused_params;
    assign unused_params = ^{UUID, NAME};

    logic in_push, in_pop, out_push, out_pop;
    logic underflow_set, overflow_set;
    logic underflow_q, underflow_d;
    logic overflow_q, overflow_d;

    // ---------------- input queue: host -> CPU ----------------
    assign host_in_ready = (in_count < FULL);
    assign in_push       = host_in_valid && host_in_ready;
    assign in_pop        = arch_input_enable && (in_count != '0);
    assign underflow_set = arch_input_enable && (in_count == '0);

    overture_io_port_fifo #(.DEPTH(DEPTH)) u_in_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_push),
        .push_data (host_in_data),
        .pop       (in_pop),
        .count     (in_count),
        .head      (arch_input_value)
    );

    // ---------------- output queue: CPU -> host ----------------
    assign host_out_valid = (out_count != '0);
    assign out_pop        = host_out_valid && host_out_ready;
    // A full queue still takes a CPU byte when the host frees a slot on the same edge.
    assign out_push       = arch_output_enable && ((out_count < FULL) || out_pop);
    assign overflow_set   = arch_output_enable && !out_push;

    overture_io_port_fifo #(.DEPTH(DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (out_push),
        .push_data (arch_output_value),
        .pop       (out_pop),
        .count     (out_count),
        .head      (host_out_data)
    );

    // ---------------- sticky error flags ----------------
    // A new error wins over a simultaneous clear.
    always_comb begin
        underflow_d = (underflow_q && !err_clear) || underflow_set;
        overflow_d  = (overflow_q  && !err_clear) || overflow_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign underflow_err = underflow_q;
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_overture_io_port.sv
// tb/tb_overture_io_port.sv - directed self-checking bench for overture_io_port with a queue-based model

module tb_overture_io_port;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          arch_input_enable;
    logic [7:0]    arch_input_value;
    logic          arch_output_enable;
    logic [7:0]    arch_output_value;
    logic          host_in_valid;
    logic [7:0]    host_in_data;
    logic          host_in_ready;
    logic          host_out_valid;
    logic [7:0]    host_out_data;
    logic          host_out_ready;
    logic [CW-1:0] in_count;
    logic [CW-1:0] out_count;
    logic          underflow_err;
    logic          overflow_err;
    logic          err_clear;

    overture_io_port #(.UUID(1), .NAME("tb"), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .arch_input_enable  (arch_input_enable),
        .arch_input_value   (arch_input_value),
        .arch_output_enable (arch_output_enable),
        .arch_output_value  (arch_output_value),
        .host_in_valid      (host_in_valid),
        .host_in_data       (host_in_data),
        .host_in_ready      (host_in_ready),
        .host_out_valid     (host_out_valid),
        .host_out_data      (host_out_data),
        .host_out_ready     (host_out_ready),
        .in_count           (in_count),
        .out_count          (out_count),
        .underflow_err      (underflow_err),
        .overflow_err       (overflow_err),
        .err_clear          (err_clear)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: plain queues and flags.
    logic [7:0] m_in[$];
    logic [7:0] m_out[$];
    logic       m_und = 1'b0;
    logic       m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; arch_input_enable = 1'b0; arch_output_enable = 1'b0;
        arch_output_value = 8'h00; host_in_valid = 1'b0; host_in_data = 8'h00;
        host_out_ready = 1'b0; err_clear = 1'b0;
    endtask

    // One clock: update the model from the inputs seen at the rising edge,
    // then compare every output to the model on the falling edge.
    task automatic tick();
        bit und, ovf, ipush, ipop, opop, opush;
        @(posedge clk);
        if (rst) begin
            m_in.delete(); m_out.delete();
            m_und = 1'b0; m_ovf = 1'b0;
        end else begin
            ipush = host_in_valid && (m_in.size() < DEPTH);
            ipop  = arch_input_enable && (m_in.size() > 0);
            und   = arch_input_enable && (m_in.size() == 0);
            opop  = host_out_ready && (m_out.size() > 0);
            opush = arch_output_enable && ((m_out.size() < DEPTH) || opop);
            ovf   = arch_output_enable && !opush;
            if (ipop)  void'(m_in.pop_front());
            if (ipush) m_in.push_back(host_in_data);
            if (opop)  void'(m_out.pop_front());
            if (opush) m_out.push_back(arch_output_value);
            m_und = (m_und && !err_clear) || und;
            m_ovf = (m_ovf && !err_clear) || ovf;
        end
        @(negedge clk);
        chk("arch_input_value", arch_input_value, (m_in.size() > 0) ? m_in[0] : 8'h00);
        chk("host_in_ready", host_in_ready, m_in.size() < DEPTH);
        chk("in_count", in_count, m_in.size());
        chk("host_out_valid", host_out_valid, m_out.size() > 0);
        chk("host_out_data", host_out_data, (m_out.size() > 0) ? m_out[0] : 8'h00);
        chk("out_count", out_count, m_out.size());
        chk("underflow_err", underflow_err, m_und);
        chk("overflow_err", overflow_err, m_ovf);
        idle();
    endtask

    task automatic host_push(input logic [7:0] d);
        host_in_valid = 1'b1; host_in_data = d; tick();
    endtask

    task automatic cpu_read();
        arch_input_enable = 1'b1; tick();
    endtask

    task automatic cpu_write(input logic [7:0] d);
        arch_output_enable = 1'b1; arch_output_value = d; tick();
    endtask

    initial begin
        idle();
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("reset in_count", in_count, 0);
        chk("reset out_count", out_count, 0);
        chk("reset host_in_ready", host_in_ready, 1);
        chk("reset host_out_valid", host_out_valid, 0);
        chk("reset arch_input_value", arch_input_value, 8'h00);

        // In-order delivery of three host bytes.
        host_push(8'h11); host_push(8'h22); host_push(8'h33);
        chk("rd0 value", arch_input_value, 8'h11); cpu_read();
        chk("rd1 value", arch_input_value, 8'h22); cpu_read();
        chk("rd2 value", arch_input_value, 8'h33); cpu_read();
        chk("after reads in_count", in_count, 0);
        chk("after reads underflow", underflow_err, 0);

        // Underflow and clear.
        chk("empty read value", arch_input_value, 8'h00);
        cpu_read();
        chk("underflow set", underflow_err, 1);
        err_clear = 1'b1; tick();
        chk("underflow cleared", underflow_err, 0);

        // Push + read on empty: underflow plus successful push, no fall-through.
        host_in_valid = 1'b1; host_in_data = 8'h5A; arch_input_enable = 1'b1; tick();
        chk("empty push+pop underflow", underflow_err, 1);
        chk("empty push+pop count", in_count, 1);
        chk("empty push+pop value", arch_input_value, 8'h5A);
        // Clear with a simultaneous new underflow: flag stays set.
        err_clear = 1'b1; tick(); cpu_read();
        err_clear = 1'b1; arch_input_enable = 1'b1; tick();
        chk("clear vs new underflow", underflow_err, 1);
        err_clear = 1'b1; tick();

        // Fill the input queue.
        for (int i = 0; i < DEPTH; i++) host_push(8'h30 + 8'(i));
        chk("in full ready", host_in_ready, 0);
        chk("in full count", in_count, DEPTH);
        host_push(8'hEE);
        chk("refused push count", in_count, DEPTH);
        cpu_read();
        chk("after pop count", in_count, DEPTH - 1);
        host_in_valid = 1'b1; host_in_data = 8'h77; arch_input_enable = 1'b1; tick();
        chk("push+pop count", in_count, DEPTH - 1);
        for (int i = 0; i < DEPTH - 2; i++) cpu_read();
        chk("pushed byte kept", arch_input_value, 8'h77);
        cpu_read();
        chk("in drained", in_count, 0);

        // Output overflow.
        for (int i = 0; i < DEPTH; i++) cpu_write(8'hA0 + 8'(i));
        chk("out full count", out_count, DEPTH);
        cpu_write(8'hFF);
        chk("overflow set", overflow_err, 1);
        chk("overflow count", out_count, DEPTH);
        err_clear = 1'b1; tick();
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain data", host_out_data, 8'hA0 + 8'(i));
            host_out_ready = 1'b1; tick();
        end
        chk("out drained valid", host_out_valid, 0);

        // Full output queue, write with simultaneous host pop.
        for (int i = 0; i < DEPTH; i++) cpu_write(8'hB0 + 8'(i));
        host_out_ready = 1'b1; arch_output_enable = 1'b1; arch_output_value = 8'hC0; tick();
        chk("full wr+pop count", out_count, DEPTH);
        chk("full wr+pop overflow", overflow_err, 0);
        chk("full wr+pop head", host_out_data, 8'hB1);

        // Reset mid-transfer with active inputs.
        host_push(8'h91); host_push(8'h92);
        cpu_write(8'hDD);
        chk("pre-reset overflow", overflow_err, 1);
        rst = 1'b1; host_in_valid = 1'b1; host_in_data = 8'h99; arch_input_enable = 1'b1;
        arch_output_enable = 1'b1; arch_output_value = 8'h88; host_out_ready = 1'b1;
        tick();
        chk("rst in_count", in_count, 0);
        chk("rst out_count", out_count, 0);
        chk("rst overflow", overflow_err, 0);
        chk("rst underflow", underflow_err, 0);
        chk("rst host_out_valid", host_out_valid, 0);
        chk("rst arch_input_value", arch_input_value, 8'h00);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
